// File: rtl/frame_composer.sv
// Frame composer: copies background, spawned-object and cursor vector templates from the
// sprite ROM into frame RAM, terminates the list, then hands the frame to the display reader.
module frame_composer #(
    parameter int unsigned COORD_W     = 8,
    parameter int unsigned ADR_WIDTH   = 10,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned NUM_OBJ     = 4,
    parameter int unsigned FRAME_MIN   = 8,
    parameter int unsigned FRAME_MAX   = 247,
    parameter int unsigned MAX_OBJ_LEN = 64,
    parameter int unsigned BG_BASE     = 0,
    parameter int unsigned CURSOR_BASE = 16,
    localparam int unsigned DATAWIDTH  = 2*COORD_W+2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           halt,
    input  logic                           frame_done,
    output logic                           go,
    output logic                           busy,
    output logic                           overflow,
    output logic [4:0]                     state_debug,
    output logic [ADR_WIDTH-1:0]           adrROM,
    input  logic [DATAWIDTH-1:0]           dataROM,
    output logic [ADR_WIDTH-1:0]           adrWRITE,
    output logic [DATAWIDTH-1:0]           dataWRITE,
    output logic                           weWRITE,
    input  logic [COORD_W-1:0]             xcursor,
    input  logic [COORD_W-1:0]             ycursor,
    input  logic [NUM_OBJ-1:0]             obj_spawn,
    input  logic [NUM_OBJ*COORD_W-1:0]     obj_x,
    input  logic [NUM_OBJ*COORD_W-1:0]     obj_y,
    input  logic [NUM_OBJ*ADR_WIDTH-1:0]   obj_base
);

    localparam int unsigned CW    = COORD_W + 2;
    localparam int unsigned OBJ_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam int unsigned TPL_W = $clog2(MAX_OBJ_LEN + 1);

    typedef enum logic [4:0] {
        StDone          = 5'd0,
        StReset         = 5'd1,
        StWaitFrameDone = 5'd2,
        StLatch         = 5'd4,
        StWriteEnd      = 5'd5,
        StDrawBg        = 5'd10,
        StDrawCursor    = 5'd12,
        StDrawObj       = 5'd13
    } state_e;

    state_e                       state_q;
    logic [NUM_OBJ-1:0]           spawn_q;
    logic [NUM_OBJ*COORD_W-1:0]   obj_x_q, obj_y_q;
    logic [NUM_OBJ*ADR_WIDTH-1:0] obj_base_q;
    logic [COORD_W-1:0]           xcur_q, ycur_q;
    logic [ADR_WIDTH-1:0]         wr_cnt_q;
    logic [TPL_W-1:0]             tpl_cnt_q;
    logic [OBJ_W-1:0]             obj_idx_q;
    logic                         we_q;

    logic [COORD_W-1:0]   pos_x, pos_y;
    logic [CW-1:0]        sum_x, sum_y;
    logic [DATAWIDTH-1:0] word_out;
    logic                 tpl_end;
    logic                 next_found;
    logic [OBJ_W-1:0]     next_idx;
    logic [ADR_WIDTH-1:0] next_base;

    function automatic logic [COORD_W-1:0] clamp(input logic signed [CW-1:0] v);
        logic [COORD_W-1:0] r;
        if (v < $signed(CW'(FRAME_MIN)))      r = COORD_W'(FRAME_MIN);
        else if (v > $signed(CW'(FRAME_MAX))) r = COORD_W'(FRAME_MAX);
        else                                  r = v[COORD_W-1:0];
        return r;
    endfunction

    always_comb begin
        pos_x = xcur_q;
        pos_y = ycur_q;
        if (state_q == StDrawObj) begin
            pos_x = obj_x_q[obj_idx_q*COORD_W +: COORD_W];
            pos_y = obj_y_q[obj_idx_q*COORD_W +: COORD_W];
        end
        // Background coordinates are absolute; object/cursor ones are signed offsets.
        if (state_q == StDrawBg) begin
            sum_x = {2'b00, dataROM[2*COORD_W-1 -: COORD_W]};
            sum_y = {2'b00, dataROM[COORD_W-1:0]};
        end else begin
            sum_x = {2'b00, pos_x}
                  + {{2{dataROM[2*COORD_W-1]}}, dataROM[2*COORD_W-1 -: COORD_W]};
            sum_y = {2'b00, pos_y} + {{2{dataROM[COORD_W-1]}}, dataROM[COORD_W-1:0]};
        end
        word_out = {1'b0, dataROM[DATAWIDTH-2], clamp(sum_x), clamp(sum_y)};
        tpl_end  = dataROM[DATAWIDTH-1] || (tpl_cnt_q == TPL_W'(MAX_OBJ_LEN - 1));

        // Lowest spawned object after the current source; descending scan keeps the lowest.
        next_found = 1'b0;
        next_idx   = '0;
        for (int i = int'(NUM_OBJ) - 1; i >= 0; i--) begin
            if (spawn_q[i] && (state_q == StDrawBg || i > int'(obj_idx_q))) begin
                next_found = 1'b1;
                next_idx   = OBJ_W'(i);
            end
        end
        next_base = next_found ? obj_base_q[next_idx*ADR_WIDTH +: ADR_WIDTH]
                               : ADR_WIDTH'(CURSOR_BASE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StReset;
            go        <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            we_q      <= 1'b0;
            adrROM    <= ADR_WIDTH'(BG_BASE);
            adrWRITE  <= '0;
            dataWRITE <= '0;
            wr_cnt_q  <= '0;
            tpl_cnt_q <= '0;
            obj_idx_q <= '0;
        end else if (halt && state_q != StReset && state_q != StWaitFrameDone) begin
            // Stalled: everything holds, the pending write stays queued behind the gate.
        end else begin
            go   <= 1'b0;
            we_q <= 1'b0;
            case (state_q)
                StReset: begin
                    busy    <= 1'b1;
                    state_q <= StLatch;
                end
                StLatch: begin
                    spawn_q    <= obj_spawn;
                    obj_x_q    <= obj_x;
                    obj_y_q    <= obj_y;
                    obj_base_q <= obj_base;
                    xcur_q     <= xcursor;
                    ycur_q     <= ycursor;
                    wr_cnt_q   <= '0;
                    tpl_cnt_q  <= '0;
                    overflow   <= 1'b0;
                    adrROM     <= ADR_WIDTH'(BG_BASE);
                    state_q    <= StDrawBg;
                end
                StDrawBg, StDrawObj, StDrawCursor: begin
                    if (wr_cnt_q == ADR_WIDTH'(DEPTH - 1)) begin
                        overflow <= 1'b1;
                        state_q  <= StWriteEnd;
                    end else begin
                        we_q      <= 1'b1;
                        dataWRITE <= word_out;
                        adrWRITE  <= wr_cnt_q;
                        wr_cnt_q  <= wr_cnt_q + 1'b1;
                        if (tpl_end) begin
                            tpl_cnt_q <= '0;
                            if (state_q == StDrawCursor) begin
                                adrROM  <= ADR_WIDTH'(BG_BASE);
                                state_q <= StWriteEnd;
                            end else begin
                                adrROM    <= next_base;
                                obj_idx_q <= next_idx;
                                state_q   <= next_found ? StDrawObj : StDrawCursor;
                            end
                        end else begin
                            tpl_cnt_q <= tpl_cnt_q + 1'b1;
                            adrROM    <= adrROM + 1'b1;
                        end
                    end
                end
                StWriteEnd: begin
                    we_q      <= 1'b1;
                    dataWRITE <= {2'b11, {(2*COORD_W){1'b0}}};
                    adrWRITE  <= wr_cnt_q;
                    busy      <= 1'b0;
                    state_q   <= StDone;
                end
                StDone: begin
                    go      <= 1'b1;
                    state_q <= StWaitFrameDone;
                end
                StWaitFrameDone: begin
                    if (frame_done) begin
                        busy    <= 1'b1;
                        state_q <= StLatch;
                    end
                end
                default: state_q <= StReset;
            endcase
        end
    end

    assign weWRITE     = we_q & ~halt;
    assign state_debug = state_q;

endmodule

// File: tb/tb_frame_composer.sv
// Bench for frame_composer: ROM/RAM models, write scoreboard, vector table for the
// coordinate transform and sequences for halt, overflow, runaway guard and handshake.
module tb_frame_composer;
    localparam int CW = 8, AW = 10, DW = 2*CW+2, NOBJ = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, halt, frame_done, rst2, fd2;
    logic go, busy, overflow, we, go2, busy2, overflow2, we2;
    logic [4:0] st, st2;
    logic [AW-1:0] adr_rom, adr_wr, adr_rom2, adr_wr2;
    logic [DW-1:0] data_rom, data_wr, data_rom2, data_wr2;
    logic [CW-1:0] xcursor, ycursor;
    logic [NOBJ-1:0] obj_spawn;
    logic [NOBJ*CW-1:0] obj_x, obj_y;
    logic [NOBJ*AW-1:0] obj_base;

    logic [DW-1:0] rom [0:1023];
    logic [DW-1:0] ram [0:1023];
    logic [DW-1:0] snap [0:11];
    assign data_rom  = rom[adr_rom];
    assign data_rom2 = rom[adr_rom2];
    always @(posedge clk) if (we) ram[adr_wr] <= data_wr;

    frame_composer dut (
        .clk(clk), .rst(rst), .halt(halt), .frame_done(frame_done), .go(go), .busy(busy),
        .overflow(overflow), .state_debug(st), .adrROM(adr_rom), .dataROM(data_rom),
        .adrWRITE(adr_wr), .dataWRITE(data_wr), .weWRITE(we), .xcursor(xcursor),
        .ycursor(ycursor), .obj_spawn(obj_spawn), .obj_x(obj_x), .obj_y(obj_y),
        .obj_base(obj_base)
    );

    frame_composer #(.DEPTH(8), .BG_BASE(200)) dut_ovf (
        .clk(clk), .rst(rst2), .halt(halt), .frame_done(fd2), .go(go2), .busy(busy2),
        .overflow(overflow2), .state_debug(st2), .adrROM(adr_rom2), .dataROM(data_rom2),
        .adrWRITE(adr_wr2), .dataWRITE(data_wr2), .weWRITE(we2), .xcursor(xcursor),
        .ycursor(ycursor), .obj_spawn(obj_spawn), .obj_x(obj_x), .obj_y(obj_y),
        .obj_base(obj_base)
    );

    typedef struct { logic [AW-1:0] adr; logic [DW-1:0] data; } wr_t;
    wr_t exp_q[$];

    typedef struct {
        int cx, cy, ox, oy, cblank, bx, by, bblank, ebx, eby, ecx, ecy;
    } vec_t;
    vec_t vt [5];

    int n_checks = 0, n_pass = 0;
    int wf, ga, ngo;
    logic [DW-1:0] end_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    endtask

    function automatic logic [DW-1:0] mk(input int last, input int blank, input int x, input int y);
        logic [CW-1:0] xs, ys;
        xs = CW'(x);
        ys = CW'(y);
        return {1'(last), 1'(blank), xs, ys};
    endfunction

    task automatic push(input int adr, input logic [DW-1:0] d);
        wr_t e;
        e.adr  = AW'(adr);
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Runs one frame to its go pulse, scoring every RAM write against exp_q.
    task automatic run_frame(input bit kick, input int halt_at, input int poke_at,
                             output int we_first, output int go_at);
        int cyc = 0;
        int hold = 0;
        bit seen_go = 1'b0;
        logic [AW-1:0] frozen = '0;
        wr_t e;
        we_first = -1;
        go_at = -1;
        if (kick) begin
            frame_done = 1'b1;
            @(negedge clk);
            frame_done = 1'b0;
        end
        while (!seen_go && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (hold > 0) begin
                check("halt_no_write", we, 0);
                check("halt_adrrom_frozen", adr_rom, frozen);
                hold--;
                if (hold == 0) halt = 1'b0;
            end
            if (we) begin
                if (we_first < 0) we_first = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: got adr=%0d data=%0h expected none",
                             adr_wr, data_wr);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_adr", adr_wr, e.adr);
                    check("wr_data", data_wr, e.data);
                end
            end
            if (go) begin
                seen_go = 1'b1;
                go_at = cyc;
                check("go_busy_low", busy, 0);
            end
            if (cyc == halt_at) begin
                check("halt_in_draw_bg", st, 10);
                halt = 1'b1;
                frozen = adr_rom;
                hold = 5;
            end
            if (cyc == poke_at) begin
                xcursor = 8'd200;
                ycursor = 8'd200;
                frame_done = 1'b1;
            end else begin
                frame_done = 1'b0;
            end
        end
        if (!seen_go) begin
            n_checks++;
            $display("FAIL go_timeout: got no go expected go within 400 cycles");
        end
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        check("go_one_cycle", go, 0);
        check("wait_state", st, 2);
    endtask

    task automatic load_halt_frame();
        for (int i = 0; i < 10; i++) rom[i] = mk(i == 9, 0, 20 + i*10, 200 - i*5);
        rom[16] = mk(1, 0, 0, 0);
        xcursor = 8'd60;
        ycursor = 8'd60;
        obj_spawn = '0;
        for (int i = 0; i < 10; i++) push(i, mk(0, 0, 20 + i*10, 200 - i*5));
        push(10, mk(0, 0, 60, 60));
        push(11, end_word);
    endtask

    initial begin
        vt[0] = '{250, 2, 10, -5, 0, 3, 100, 0, 8, 100, 247, 8};
        vt[1] = '{0, 0, -1, -128, 0, 250, 0, 0, 247, 8, 8, 8};
        vt[2] = '{255, 255, 127, 127, 1, 128, 247, 0, 128, 247, 247, 247};
        vt[3] = '{120, 130, -20, 7, 0, 8, 9, 1, 8, 9, 100, 137};
        vt[4] = '{10, 250, -2, -3, 0, 255, 7, 0, 247, 8, 8, 247};
        end_word = mk(1, 1, 0, 0);
        rst = 1'b1; rst2 = 1'b1; halt = 1'b0; frame_done = 1'b0; fd2 = 1'b0;
        xcursor = '0; ycursor = '0; obj_spawn = '0; obj_x = '0; obj_y = '0; obj_base = '0;
        for (int i = 0; i < 1024; i++) rom[i] = '0;
        repeat (3) @(negedge clk);

        check("rst_go", go, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_we", we, 0);
        check("rst_adrrom", adr_rom, 0);
        check("rst_adrwrite", adr_wr, 0);
        check("rst_datawrite", data_wr, 0);
        check("rst_state", st, 1);

        // Basic frame: 3 BG words, 2 cursor words.
        rom[0] = mk(0, 0, 50, 60); rom[1] = mk(0, 1, 70, 80); rom[2] = mk(1, 0, 90, 100);
        rom[16] = mk(0, 0, 1, -1); rom[17] = mk(1, 0, -2, 3);
        xcursor = 8'd100; ycursor = 8'd120;
        push(0, mk(0, 0, 50, 60)); push(1, mk(0, 1, 70, 80)); push(2, mk(0, 0, 90, 100));
        push(3, mk(0, 0, 101, 119)); push(4, mk(0, 0, 98, 123)); push(5, end_word);
        rst = 1'b0;
        run_frame(1'b0, -1, -1, wf, ga);
        check("basic_go_latency", ga - wf, 6);
        check("basic_no_overflow", overflow, 0);

        // Spawn mask 0101: obj0 then obj2, obj1/obj3 skipped.
        rom[32] = mk(1, 0, 0, 0); rom[40] = mk(1, 0, 5, 5);
        rom[48] = mk(1, 0, 0, 0); rom[56] = mk(1, 0, 7, 7);
        obj_base = {10'd56, 10'd48, 10'd40, 10'd32};
        obj_x = {8'd90, 8'd30, 8'd80, 8'd200};
        obj_y = {8'd91, 8'd30, 8'd81, 8'd53};
        obj_spawn = 4'b0101;
        xcursor = 8'd60; ycursor = 8'd60;
        push(0, mk(0, 0, 50, 60)); push(1, mk(0, 1, 70, 80)); push(2, mk(0, 0, 90, 100));
        push(3, mk(0, 0, 200, 53)); push(4, mk(0, 0, 30, 30));
        push(5, mk(0, 0, 61, 59)); push(6, mk(0, 0, 58, 63)); push(7, end_word);
        repeat (2) @(negedge clk);
        run_frame(1'b1, -1, -1, wf, ga);
        check("spawn_go_latency", ga - wf, 8);

        // Transform/clamp vectors: 1-word BG and 1-word cursor per frame.
        obj_spawn = '0;
        for (int k = 0; k < 5; k++) begin
            rom[0]  = mk(1, vt[k].bblank, vt[k].bx, vt[k].by);
            rom[16] = mk(1, vt[k].cblank, vt[k].ox, vt[k].oy);
            xcursor = CW'(vt[k].cx);
            ycursor = CW'(vt[k].cy);
            push(0, mk(0, vt[k].bblank, vt[k].ebx, vt[k].eby));
            push(1, mk(0, vt[k].cblank, vt[k].ecx, vt[k].ecy));
            push(2, end_word);
            repeat (2) @(negedge clk);
            run_frame(1'b1, -1, -1, wf, ga);
        end

        // Unhalted reference frame.
        load_halt_frame();
        repeat (2) @(negedge clk);
        run_frame(1'b1, -1, -1, wf, ga);
        for (int i = 0; i < 12; i++) snap[i] = ram[i];

        // Runaway guard: object template without a last bit.
        rom[0] = mk(1, 0, 50, 60);
        rom[16] = mk(1, 0, 0, 0);
        for (int i = 0; i < 100; i++) rom[100 + i] = mk(0, i & 1, i + 10, i);
        obj_base = {10'd56, 10'd48, 10'd40, 10'd100};
        obj_x = {8'd0, 8'd0, 8'd0, 8'd20};
        obj_y = {8'd0, 8'd0, 8'd0, 8'd20};
        obj_spawn = 4'b0001;
        push(0, mk(0, 0, 50, 60));
        for (int i = 0; i < 64; i++) push(1 + i, mk(0, i & 1, 30 + i, 20 + i));
        push(65, mk(0, 0, 60, 60));
        push(66, end_word);
        repeat (2) @(negedge clk);
        run_frame(1'b1, -1, -1, wf, ga);
        check("runaway_go_latency", ga - wf, 67);

        // Same frame as the reference, halted for 5 cycles mid-background.
        load_halt_frame();
        repeat (2) @(negedge clk);
        run_frame(1'b1, 4, -1, wf, ga);
        for (int i = 0; i < 12; i++) check("halt_ram_same", ram[i], snap[i]);

        // Handshake: 4 frames, cursor moved and frame_done pulsed mid-frame.
        rom[0] = mk(1, 0, 50, 60);
        rom[16] = mk(1, 0, 0, 0);
        ngo = 0;
        for (int k = 0; k < 4; k++) begin
            xcursor = CW'(40 + 20*k);
            ycursor = CW'(45 + 20*k);
            push(0, mk(0, 0, 50, 60));
            push(1, mk(0, 0, 40 + 20*k, 45 + 20*k));
            push(2, end_word);
            repeat (2) @(negedge clk);
            run_frame(1'b1, -1, 1, wf, ga);
            if (ga >= 0) ngo++;
        end
        check("handshake_go_count", ngo, 4);

        // Frame 5 abandoned by reset mid-frame, then a clean frame after release.
        repeat (2) @(negedge clk);
        xcursor = 8'd33; ycursor = 8'd44;
        ngo = 0;
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (go) ngo++;
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (go) ngo++;
        end
        check("midrst_no_go", ngo, 0);
        check("midrst_busy", busy, 0);
        check("midrst_we", we, 0);
        check("midrst_state", st, 1);
        check("midrst_adrrom", adr_rom, 0);
        check("midrst_adrwrite", adr_wr, 0);
        check("midrst_datawrite", data_wr, 0);
        push(0, mk(0, 0, 50, 60)); push(1, mk(0, 0, 33, 44)); push(2, end_word);
        rst = 1'b0;
        run_frame(1'b0, -1, -1, wf, ga);

        // Overflow on the 8-deep instance: 20-word background.
        for (int i = 0; i < 20; i++) rom[200 + i] = mk(i == 19, 0, 20 + i, 30 + i);
        rst2 = 1'b0;
        begin
            int n = 0;
            bit got = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk);
                if (we2) begin
                    check("ovf_adr_in_range", adr_wr2 <= 7, 1);
                    check("ovf_adr", adr_wr2, n);
                    check("ovf_data", data_wr2, (n < 7) ? mk(0, 0, 20 + n, 30 + n) : end_word);
                    n++;
                end
                if (go2) begin
                    got = 1'b1;
                    check("ovf_flag_at_go", overflow2, 1);
                end
            end
            if (!got) begin
                n_checks++;
                $display("FAIL ovf_go_timeout: got no go expected go within 100 cycles");
            end
            check("ovf_write_count", n, 8);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
